fetch_ctrl: RTL and testbench

//  Instruction-fetch sequencer for the pipelined MIPS core. Owns the PC, drives the

---
 rtl/fetch_ctrl_pkg.sv | 30 +++
 rtl/fetch_ctrl_if.sv | 29 ++
 rtl/fetch_ctrl_fifo.sv | 59 +++++
 rtl/fetch_ctrl.sv | 82 ++++++++
 tb/tb_fetch_ctrl.sv | 192 +++++++++++++++++++
 5 files changed

// File: rtl/fetch_ctrl_pkg.sv
// Shared types and defaults for the instruction-fetch sequencer.
// Holds the text base, the IM size, and the bad-PC check.
package fetch_ctrl_pkg;

   localparam logic [31:0] DEFAULT_RESET_PC = 32'h0000_3000;
   localparam int          DEFAULT_IM_AW    = 10;

   typedef enum logic {
      RUN,
      HALT
   } fetch_state_t;

   typedef struct packed {
      logic [31:0] pc;
      logic [31:0] instr;
   } fetch_entry_t;

   // A PC is unusable if it is misaligned or falls outside the IM window.
   // Addresses below the base wrap to a huge offset, so they also fail.
   function automatic logic pc_is_bad(input logic [31:0] pc,
                                      input logic [31:0] base,
                                      input int unsigned im_aw);
      logic [31:0] offset;
      logic [32:0] limit;
      offset = pc - base;
      limit  = 33'd4 << im_aw;
      return (pc[1:0] != 2'b00) || ({1'b0, offset} >= limit);
   endfunction

endpackage

// File: rtl/fetch_ctrl_if.sv
// IF->ID handshake and redirect request bundle of the fetch sequencer.
interface fetch_ctrl_if;

   logic        if_valid;
   logic [31:0] if_instr;
   logic [31:0] if_pc;
   logic        id_ready;
   logic        redirect_valid;
   logic [31:0] redirect_pc;

   modport master (
      output if_valid,
      output if_instr,
      output if_pc,
      input  id_ready,
      input  redirect_valid,
      input  redirect_pc
   );

   modport slave (
      input  if_valid,
      input  if_instr,
      input  if_pc,
      output id_ready,
      output redirect_valid,
      output redirect_pc
   );

endinterface

// File: rtl/fetch_ctrl_fifo.sv
// Two-entry {pc,instr} fetch FIFO; slot0 is always the registered head.
// Flush beats enqueue, and the head reads as zero while the FIFO is empty.
module fetch_ctrl_fifo
   import fetch_ctrl_pkg::*;
(
   input  logic         clk,
   input  logic         rst_n,
   input  logic         flush,
   input  logic         enq,
   input  logic         deq,
   input  fetch_entry_t din,
   output logic         full,
   output logic         empty,
   output fetch_entry_t head
);

   fetch_entry_t slot0;
   fetch_entry_t slot1;
   logic [1:0]   count;
   logic         deq_ok;
   logic         enq_ok;

   assign empty  = (count == 2'd0);
   assign full   = (count == 2'd2);
   assign deq_ok = deq && !empty;
   assign enq_ok = enq && (!full || deq_ok);
   assign head   = empty ? '0 : slot0;

   always_ff @(posedge clk) begin
      if (!rst_n || flush) begin
         count <= 2'd0;
         slot0 <= '0;
         slot1 <= '0;
      end else begin
         case ({enq_ok, deq_ok})
            2'b11: begin
               // Count is unchanged; with two entries the tail shifts up.
               if (count == 2'd2) begin
                  slot0 <= slot1;
                  slot1 <= din;
               end else begin
                  slot0 <= din;
               end
            end
            2'b10: begin
               if (count == 2'd0) slot0 <= din;
               else               slot1 <= din;
               count <= count + 2'd1;
            end
            2'b01: begin
               slot0 <= slot1;
               count <= count - 2'd1;
            end
            default: ;
         endcase
      end
   end

endmodule

// File: rtl/fetch_ctrl.sv
// Instruction-fetch sequencer: owns the PC, addresses the 1K IM, queues
// fetched {pc,instr} pairs for ID, and halts on an out-of-range PC.
module fetch_ctrl
   import fetch_ctrl_pkg::*;
#(
   parameter logic [31:0] RESET_PC = DEFAULT_RESET_PC,
   parameter int          IM_AW    = DEFAULT_IM_AW
)(
   input  logic              clk,
   input  logic              rst_n,
   fetch_ctrl_if.master      bus,
   output logic [IM_AW-1:0]  im_addr,
   input  logic [31:0]       im_dout,
   output logic              fault,
   output logic [31:0]       fault_pc
);

   fetch_state_t state;
   fetch_state_t next_state;
   logic [31:0]  pc;
   logic         pc_bad;
   logic         redirect;
   logic         deq;
   logic         fetch_en;
   logic         fifo_full;
   logic         fifo_empty;
   fetch_entry_t fifo_head;

   assign redirect = bus.redirect_valid;
   assign pc_bad   = pc_is_bad(pc, RESET_PC, IM_AW);
   assign deq      = bus.if_valid && bus.id_ready;

   // The base is word aligned, so the word-index subtraction never borrows
   // from the byte-offset bits and matches (pc - RESET_PC)[IM_AW+1:2].
   assign im_addr = pc[IM_AW+1:2] - RESET_PC[IM_AW+1:2];

   always_ff @(posedge clk) begin
      if (!rst_n) state <= RUN;
      else        state <= next_state;
   end

   always_comb begin
      next_state = state;
      if (redirect)                    next_state = RUN;
      else if (state == RUN && pc_bad) next_state = HALT;
   end

   always_comb begin
      fault    = (state == HALT);
      fetch_en = (state == RUN) && !pc_bad && !redirect && (!fifo_full || deq);
   end

   // A redirect outranks both the sequential advance and fault capture.
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         pc       <= RESET_PC;
         fault_pc <= 32'd0;
      end else if (redirect) begin
         pc <= bus.redirect_pc;
      end else begin
         if (fetch_en) pc <= pc + 32'd4;
         if (state == RUN && pc_bad) fault_pc <= pc;
      end
   end

   fetch_ctrl_fifo u_fifo (
      .clk   (clk),
      .rst_n (rst_n),
      .flush (redirect),
      .enq   (fetch_en),
      .deq   (deq),
      .din   ('{pc: pc, instr: im_dout}),
      .full  (fifo_full),
      .empty (fifo_empty),
      .head  (fifo_head)
   );

   assign bus.if_valid = !fifo_empty;
   assign bus.if_pc    = fifo_head.pc;
   assign bus.if_instr = fifo_head.instr;

endmodule

// File: tb/tb_fetch_ctrl.sv
// Scoreboard bench for fetch_ctrl: directed stimulus queues expected
// {pc,instr} deliveries, and a negedge monitor checks every ID transfer.
module tb_fetch_ctrl;

   logic        clk = 1'b0;
   logic        rst_n = 1'b0;
   logic [9:0]  im_addr;
   logic [31:0] im_dout;
   logic        fault;
   logic [31:0] fault_pc;

   int compared = 0;
   int mismatched = 0;

   logic [63:0] sb[$];
   logic [63:0] mon_exp;

   fetch_ctrl_if bus();

   fetch_ctrl #(.RESET_PC(32'h0000_3000), .IM_AW(10)) dut (
      .clk      (clk),
      .rst_n    (rst_n),
      .bus      (bus),
      .im_addr  (im_addr),
      .im_dout  (im_dout),
      .fault    (fault),
      .fault_pc (fault_pc)
   );

   always #5 clk = ~clk;

   // Behavioural IM: each word holds a tag plus its own word index.
   assign im_dout = 32'hA000_0000 | {22'd0, im_addr};

   function automatic logic [63:0] entry(input logic [31:0] pc);
      logic [31:0] instr;
      instr = 32'hA000_0000 | ((pc - 32'h0000_3000) >> 2);
      return {pc, instr};
   endfunction

   task automatic push_expected(input logic [31:0] pc);
      sb.push_back(entry(pc));
   endtask

   task automatic checkOutput(input string name, input logic [31:0] actual,
                              input logic [31:0] expected);
      compared++;
      if (actual !== expected) begin
         mismatched++;
         $display("[TB] FAIL %s: got %h, expected %h", name, actual, expected);
      end
   endtask

   task automatic applyStimulus(input logic rdy, input logic rv,
                                input logic [31:0] rpc, input int cycles);
      bus.id_ready       = rdy;
      bus.redirect_valid = rv;
      bus.redirect_pc    = rpc;
      repeat (cycles) begin
         @(posedge clk);
         #1;
      end
   endtask

   task automatic doReset(input int cycles, input string tag);
      rst_n              = 1'b0;
      bus.id_ready       = 1'b0;
      bus.redirect_valid = 1'b0;
      bus.redirect_pc    = 32'd0;
      repeat (cycles) begin
         @(posedge clk);
         #1;
      end
      checkOutput({tag, "_if_valid"}, {31'd0, bus.if_valid}, 32'd0);
      checkOutput({tag, "_if_pc"}, bus.if_pc, 32'd0);
      checkOutput({tag, "_if_instr"}, bus.if_instr, 32'd0);
      checkOutput({tag, "_fault"}, {31'd0, fault}, 32'd0);
      checkOutput({tag, "_fault_pc"}, fault_pc, 32'd0);
      rst_n = 1'b1;
   endtask

   // Every head transfer must match the oldest outstanding expectation.
   always @(negedge clk) begin
      if (rst_n && bus.if_valid && bus.id_ready) begin
         compared++;
         if (sb.size() == 0) begin
            mismatched++;
            $display("[TB] FAIL unexpected_delivery: got pc %h instr %h, expected none",
                     bus.if_pc, bus.if_instr);
         end else begin
            mon_exp = sb.pop_front();
            if ({bus.if_pc, bus.if_instr} !== mon_exp) begin
               mismatched++;
               $display("[TB] FAIL delivery: got pc %h instr %h, expected pc %h instr %h",
                        bus.if_pc, bus.if_instr, mon_exp[63:32], mon_exp[31:0]);
            end
         end
      end
   end

   initial begin
      bus.id_ready       = 1'b0;
      bus.redirect_valid = 1'b0;
      bus.redirect_pc    = 32'd0;

      $display("[TB] test 1: stream after reset");
      doReset(2, "reset1");
      push_expected(32'h3000);
      push_expected(32'h3004);
      push_expected(32'h3008);
      applyStimulus(1'b1, 1'b0, 32'd0, 4);
      applyStimulus(1'b0, 1'b0, 32'd0, 1);
      checkOutput("t1_drained", 32'(sb.size()), 32'd0);

      $display("[TB] test 2: back-pressure fills the queue");
      doReset(1, "reset2");
      applyStimulus(1'b0, 1'b0, 32'd0, 5);
      checkOutput("t2_if_valid", {31'd0, bus.if_valid}, 32'd1);
      checkOutput("t2_head_pc", bus.if_pc, 32'h3000);
      checkOutput("t2_head_instr", bus.if_instr, 32'hA000_0000);
      checkOutput("t2_stalled_addr", {22'd0, im_addr}, 32'd2);
      push_expected(32'h3000);
      push_expected(32'h3004);
      push_expected(32'h3008);
      applyStimulus(1'b1, 1'b0, 32'd0, 3);
      applyStimulus(1'b0, 1'b0, 32'd0, 0);
      checkOutput("t2_drained", 32'(sb.size()), 32'd0);

      $display("[TB] test 3: redirect with full queue");
      push_expected(32'h300C);
      applyStimulus(1'b1, 1'b1, 32'h3100, 1);
      checkOutput("t3_flushed", {31'd0, bus.if_valid}, 32'd0);
      push_expected(32'h3100);
      push_expected(32'h3104);
      applyStimulus(1'b1, 1'b0, 32'd0, 1);
      checkOutput("t3_target_pc", bus.if_pc, 32'h3100);
      checkOutput("t3_target_instr", bus.if_instr, 32'hA000_0040);
      applyStimulus(1'b1, 1'b0, 32'd0, 2);
      applyStimulus(1'b0, 1'b0, 32'd0, 0);
      checkOutput("t3_drained", 32'(sb.size()), 32'd0);

      $display("[TB] test 4: run off the end of IM");
      applyStimulus(1'b0, 1'b1, 32'h3FF0, 1);
      push_expected(32'h3FF0);
      push_expected(32'h3FF4);
      push_expected(32'h3FF8);
      push_expected(32'h3FFC);
      applyStimulus(1'b1, 1'b0, 32'd0, 6);
      checkOutput("t4_fault", {31'd0, fault}, 32'd1);
      checkOutput("t4_fault_pc", fault_pc, 32'h4000);
      checkOutput("t4_if_valid", {31'd0, bus.if_valid}, 32'd0);
      checkOutput("t4_drained", 32'(sb.size()), 32'd0);
      applyStimulus(1'b1, 1'b1, 32'h3000, 1);
      checkOutput("t4_fault_cleared", {31'd0, fault}, 32'd0);
      checkOutput("t4_fault_pc_kept", fault_pc, 32'h4000);
      push_expected(32'h3000);
      push_expected(32'h3004);
      applyStimulus(1'b1, 1'b0, 32'd0, 3);
      applyStimulus(1'b0, 1'b0, 32'd0, 1);
      checkOutput("t4_resumed", 32'(sb.size()), 32'd0);

      $display("[TB] test 5: misaligned and below-base redirects");
      applyStimulus(1'b0, 1'b1, 32'h3002, 1);
      checkOutput("t5_no_fault_yet", {31'd0, fault}, 32'd0);
      applyStimulus(1'b0, 1'b0, 32'd0, 1);
      checkOutput("t5_misaligned_fault", {31'd0, fault}, 32'd1);
      checkOutput("t5_misaligned_pc", fault_pc, 32'h3002);
      checkOutput("t5_misaligned_empty", {31'd0, bus.if_valid}, 32'd0);
      applyStimulus(1'b0, 1'b1, 32'h2FFC, 1);
      checkOutput("t5_redirect_clears", {31'd0, fault}, 32'd0);
      applyStimulus(1'b1, 1'b0, 32'd0, 2);
      checkOutput("t5_below_fault", {31'd0, fault}, 32'd1);
      checkOutput("t5_below_pc", fault_pc, 32'h2FFC);
      checkOutput("t5_below_empty", {31'd0, bus.if_valid}, 32'd0);

      $display("[TB] test 6: reset mid-stream");
      applyStimulus(1'b0, 1'b1, 32'h3000, 1);
      applyStimulus(1'b0, 1'b0, 32'd0, 3);
      checkOutput("t6_full_valid", {31'd0, bus.if_valid}, 32'd1);
      checkOutput("t6_full_head", bus.if_pc, 32'h3000);
      doReset(1, "reset6");
      push_expected(32'h3000);
      push_expected(32'h3004);
      applyStimulus(1'b1, 1'b0, 32'd0, 3);
      applyStimulus(1'b0, 1'b0, 32'd0, 2);
      checkOutput("t6_drained", 32'(sb.size()), 32'd0);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
      $finish;
   end

endmodule
